// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the instruction loader:
//   - widths for the instruction memory port (ADDR_W, DATA_W)
//   - bytes per instruction word and the byte-counter width
//   - load_state_t : FSM state encoding
//   - xor_fold     : running checksum helper
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package inst_loader_pkg;

  localparam int ADDR_W         = 6;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = 2;

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } load_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd4
  } load_state_t;
`endif

  // Folds one written word into the running XOR checksum.
  function automatic logic [DATA_W-1:0] xor_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// inst_loader_byte_packer
// Assembles serial bytes into a big-endian 32-bit word. The first accepted
// byte ends up in bits [31:24], the fourth in bits [7:0].
// Ports:
//   clka, rst     clock / asynchronous active-high reset
//   clr           restarts the byte counter at the beginning of a session
//   accept        a byte is taken this cycle (valid && ready handshake)
//   byte_data     incoming byte
//   word          assembled word (shift register contents)
//   word_ready    combinational pulse: this accept completes a word
// -----------------------------------------------------------------------------
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clka,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  logic [BCNT_W-1:0] cnt_r;
  logic [DATA_W-1:0] shift_r;

  assign word       = shift_r;
  assign word_ready = accept && (cnt_r == LAST_BYTE);

  // Byte counter: wraps 3 -> 0 naturally, so a stalled word keeps its position.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      cnt_r <= {BCNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {BCNT_W{1'b0}};
    end else if (accept) begin
      cnt_r <= cnt_r + BCNT_W'(1);
    end
  end

  // Shift register: older bytes move toward the MSB, giving big-endian order.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      shift_r <= {DATA_W{1'b0}};
    end else if (accept) begin
      shift_r <= {shift_r[DATA_W-9:0], byte_data};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads WORDS 32-bit instruction words from a byte stream into instruction
// memory. Each word is collected from four bytes and written in a single
// one-cycle WRITE state; the session ends in DONE with load_done held high.
// Optional macro INST_LOADER_CHECKSUM_EN: XOR of all written words is compared
// against four trailing checksum bytes, result on chk_ok.
// Ports:
//   clka, rst            clock / asynchronous active-high reset
//   start                one-cycle pulse starting a session (ignored when busy)
//   byte_valid/byte_data serial byte input, handshake with byte_ready
//   wea/addra/dina       instruction memory write port
//   busy                 session in progress
//   load_done            session complete, held until next start
//   chk_ok               checksum result
// -----------------------------------------------------------------------------
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int WORDS = 64
)
(
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              load_done,
  output logic              chk_ok
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  load_state_t       state_r;
  load_state_t       state_nxt_s;
  logic              byte_ready_r;
  logic              wea_r;
  logic              busy_r;
  logic              load_done_r;
  logic              chk_ok_r;
  logic [ADDR_W-1:0] addra_r;
  logic              byte_ready_nxt_s;
  logic              wea_nxt_s;
  logic              busy_nxt_s;
  logic              load_done_nxt_s;
  logic              start_ok_s;
  logic              accept_s;
  logic              word_ready_s;
  logic              last_addr_s;
  logic [DATA_W-1:0] word_s;

  // A start only counts when no session is running.
  assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign accept_s    = byte_valid && byte_ready_r;
  assign last_addr_s = (addra_r == LAST_ADDR);

  assign byte_ready = byte_ready_r;
  assign wea        = wea_r;
  assign addra      = addra_r;
  assign dina       = word_s;
  assign busy       = busy_r;
  assign load_done  = load_done_r;
  assign chk_ok     = chk_ok_r;

  inst_loader_byte_packer u_packer (
    .clka       (clka),
    .rst        (rst),
    .clr        (start_ok_s),
    .accept     (accept_s),
    .byte_data  (byte_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // State register.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_COLLECT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (word_ready_s) state_nxt_s = ST_WRITE;
        else              state_nxt_s = ST_COLLECT;
      end
      ST_WRITE: begin
        if (last_addr_s) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_nxt_s = ST_CHECK;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (word_ready_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_CHECK;
      end
`endif
      ST_DONE: begin
        if (start) state_nxt_s = ST_COLLECT;
        else       state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    byte_ready_nxt_s = 1'b0;
    wea_nxt_s        = 1'b0;
    busy_nxt_s       = 1'b0;
    load_done_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_COLLECT: begin
        byte_ready_nxt_s = 1'b1;
        busy_nxt_s       = 1'b1;
      end
      ST_WRITE: begin
        wea_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready_nxt_s = 1'b1;
        busy_nxt_s       = 1'b1;
      end
`endif
      ST_DONE: begin
        load_done_nxt_s = 1'b1;
      end
      default: begin
        byte_ready_nxt_s = 1'b0;
        wea_nxt_s        = 1'b0;
        busy_nxt_s       = 1'b0;
        load_done_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      byte_ready_r <= 1'b0;
      wea_r        <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      byte_ready_r <= byte_ready_nxt_s;
      wea_r        <= wea_nxt_s;
      busy_r       <= busy_nxt_s;
      load_done_r  <= load_done_nxt_s;
    end
  end

  // Word address: restarts at 0 per session, advances after each non-final write.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      addra_r <= {ADDR_W{1'b0}};
    end else if (start_ok_s) begin
      addra_r <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_WRITE) && !last_addr_s) begin
      addra_r <= addra_r + ADDR_W'(1);
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_r;

  // Running XOR of every word written this session.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      acc_r <= {DATA_W{1'b0}};
    end else if (start_ok_s) begin
      acc_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_WRITE) begin
      acc_r <= xor_fold(acc_r, word_s);
    end
  end

  // Checksum verdict, taken on the fourth checksum byte (entry to DONE);
  // the received value is the three buffered bytes plus the incoming one.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      chk_ok_r <= 1'b0;
    end else if (start_ok_s) begin
      chk_ok_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && word_ready_s) begin
      chk_ok_r <= ({word_s[DATA_W-9:0], byte_data} == acc_r);
    end
  end
`else
  // Without a checksum the result simply reports a completed session.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      chk_ok_r <= 1'b0;
    end else begin
      chk_ok_r <= (state_nxt_s == ST_DONE);
    end
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Self-checking bench for inst_loader (WORDS=64). Random program words are
// streamed byte by byte with random gaps; a reference memory image and XOR
// checksum kept in the bench give the expected writes and chk_ok.
// Honours INST_LOADER_CHECKSUM_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_inst_loader;

  localparam int WORDS = 64;

  logic        clka = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wea;
  logic [5:0]  addra;
  logic [31:0] dina;
  logic        busy;
  logic        load_done;
  logic        chk_ok;

  int n_assert   = 0;
  int n_fail     = 0;
  int wea_cnt    = 0;
  int max_addr   = 0;
  int exp_writes = 0;
  logic [31:0] exp_mem [WORDS];

  inst_loader #(.WORDS(WORDS)) u_dut (
    .clka       (clka),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .busy       (busy),
    .load_done  (load_done),
    .chk_ok     (chk_ok)
  );

  always #5 clka = ~clka;

  // Counts every write pulse and tracks the highest address ever written.
  always @(negedge clka) begin
    if (wea === 1'b1) begin
      wea_cnt++;
      if (int'(addra) > max_addr) max_addr = int'(addra);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clka);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clka);
      n++;
    end
    if (n >= 40) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clka);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clka);
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    check("start_busy",      32'(busy),       32'd1);
    check("start_ready",     32'(byte_ready), 32'd1);
    check("start_addra",     32'(addra),      32'd0);
    check("start_load_done", 32'(load_done),  32'd0);
    check("start_chk_ok",    32'(chk_ok),     32'd0);
  endtask

  // Send a word; the write must appear in the very next cycle.
  task automatic load_word(input int a, input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], int'($urandom_range(0, maxgap)));
    exp_writes++;
    check("wr_wea",   32'(wea),        32'd1);
    check("wr_addra", 32'(addra),      32'(a));
    check("wr_dina",  dina,            w);
    check("wr_ready", 32'(byte_ready), 32'd0);
    check("wr_busy",  32'(busy),       32'd1);
  endtask

  task automatic run_session(input int maxgap, input bit start_mid, input bit good_sum);
    logic [31:0] acc;
    logic [31:0] sum;
    acc = 32'd0;
    pulse_start();
    for (int i = 0; i < WORDS; i++) begin
      exp_mem[i] = $urandom;
      acc = acc ^ exp_mem[i];
      if (start_mid && i == 10) begin
        start = 1'b1;
        repeat (2) @(negedge clka);
        start = 1'b0;
        check("mid_start_addra", 32'(addra), 32'd10);
        check("mid_start_busy",  32'(busy),  32'd1);
      end
      load_word(i, exp_mem[i], maxgap);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    @(negedge clka);
    check("chk_state_ready", 32'(byte_ready), 32'd1);
    check("chk_state_busy",  32'(busy),       32'd1);
    check("chk_state_wea",   32'(wea),        32'd0);
    sum = good_sum ? acc : (acc ^ 32'h0000_0100);
    for (int k = 0; k < 4; k++) send_byte(sum[31-8*k -: 8], int'($urandom_range(0, maxgap)));
    check("done_chk_ok", 32'(chk_ok), 32'(good_sum));
`else
    sum = acc;
    @(negedge clka);
    check("done_chk_ok", 32'(chk_ok), 32'd1);
`endif
    check("done_load_done", 32'(load_done),  32'd1);
    check("done_busy",      32'(busy),       32'd0);
    check("done_ready",     32'(byte_ready), 32'd0);
    check("done_wea",       32'(wea),        32'd0);
    check("done_addra",     32'(addra),      32'(WORDS - 1));
    #2;
    check("session_wea_count", 32'(wea_cnt), 32'(exp_writes));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clka);
    check("rst_wea",       32'(wea),        32'd0);
    check("rst_ready",     32'(byte_ready), 32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_load_done", 32'(load_done),  32'd0);
    check("rst_chk_ok",    32'(chk_ok),     32'd0);
    check("rst_addra",     32'(addra),      32'd0);
    check("rst_dina",      dina,            32'd0);
    rst = 1'b0;

    // Bytes while idle must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (5) @(negedge clka);
    byte_valid = 1'b0;
    #2;
    check("idle_no_wea", 32'(wea_cnt), 32'd0);

    // Session A: back-to-back bytes, stray start mid-session, good checksum.
    run_session(0, 1'b1, 1'b1);

    // Bytes offered in DONE are ignored and the state is held.
    byte_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      byte_data = 8'($urandom);
      @(negedge clka);
    end
    byte_valid = 1'b0;
    #2;
    check("done_hold_wea_count", 32'(wea_cnt),   32'(exp_writes));
    check("done_hold_load_done", 32'(load_done), 32'd1);

    // Session B: random gaps between bytes, wrong checksum.
    run_session(3, 1'b0, 1'b0);

    // Reset in the middle of word 5, after two of its bytes.
    pulse_start();
    for (int i = 0; i < 5; i++) load_word(i, $urandom, 1);
    send_byte(8'hC3, 0);
    send_byte(8'h3C, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wea",       32'(wea),        32'd0);
    check("mid_rst_ready",     32'(byte_ready), 32'd0);
    check("mid_rst_busy",      32'(busy),       32'd0);
    check("mid_rst_load_done", 32'(load_done),  32'd0);
    check("mid_rst_chk_ok",    32'(chk_ok),     32'd0);
    check("mid_rst_addra",     32'(addra),      32'd0);
    check("mid_rst_dina",      dina,            32'd0);
    @(negedge clka);
    rst = 1'b0;
    byte_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      byte_data = 8'($urandom);
      @(negedge clka);
    end
    byte_valid = 1'b0;
    #2;
    check("post_rst_no_wea", 32'(wea_cnt), 32'(exp_writes));
    check("post_rst_busy",   32'(busy),    32'd0);

    // Session C after the abandoned load: writes start again at address 0.
    run_session(1, 1'b0, 1'b1);

    #2;
    check("max_addra",       32'(max_addr), 32'(WORDS - 1));
    check("total_wea_count", 32'(wea_cnt),  32'(exp_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter WORDS, default 64, number of 32-bit words loaded per program (legal 1..64).
REQ-002 clka  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a load session.
REQ-005 byte_valid  input  1  serial byte present on byte_data.
REQ-006 byte_data  input  8  program byte; big-endian within each word.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 wea  output  1  instruction memory write enable.
REQ-009 addra  output  6  instruction memory word address.
REQ-010 dina  output  32  instruction memory write data.
REQ-011 busy  output  1  session in progress.
REQ-012 load_done  output  1  session complete; held until next start.
REQ-013 chk_ok  output  1  checksum result; see Configuration.

Function
REQ-014 States: IDLE, COLLECT, WRITE, CHECK (only with CHECKSUM_EN), DONE.
REQ-015 IDLE: byte_ready=0, wea=0; start -> COLLECT, addra:=0, byte counter:=0, load_done:=0.
REQ-016 COLLECT: byte_ready=1; byte accepted only when byte_valid && byte_ready; first accepted byte goes to dina[31:24], fourth to dina[7:0].
REQ-017 On fourth accepted byte -> WRITE next cycle; byte counter wraps 3->0.
REQ-018 WRITE: exactly one cycle, wea=1, byte_ready=0, addra/dina stable and valid.
REQ-019 After WRITE: if addra==WORDS-1 -> DONE (or CHECK when enabled), else addra:=addra+1, -> COLLECT.
REQ-020 Latency: wea asserts the cycle after the fourth byte handshake; max throughput one word per 5 cycles.
REQ-021 DONE: load_done=1, busy=0, byte_ready=0; start -> COLLECT (new session, addra:=0).
REQ-022 busy=1 in COLLECT, WRITE, CHECK; 0 in IDLE, DONE.
REQ-023 start while busy is ignored; byte_valid outside COLLECT/CHECK is ignored.
REQ-024 addra never exceeds WORDS-1; no write beyond the last word.
REQ-025 byte_valid deasserted mid-word: partial word retained, collection resumes on next valid byte.

Reset
REQ-026 rst forces IDLE, addra=0, dina=0, byte counter=0, wea=0, byte_ready=0, busy=0, load_done=0, checksum accumulator=0, chk_ok=0, asynchronously.
REQ-027 rst mid-session abandons the load; no further wea pulses after rst release until a new start.

Configuration
REQ-028 Macro INST_LOADER_CHECKSUM_EN: when defined, XOR of all written words accumulates; after last WRITE, CHECK collects 4 further bytes (big-endian) without writing; chk_ok:=(received==accumulator) on entry to DONE.
REQ-029 When undefined: no CHECK state, no accumulator; chk_ok=1 in DONE, 0 elsewhere.
REQ-030 Accumulator and chk_ok clear on start.

Structure
REQ-031 Shared package holds state encoding typedef, ADDR_W=6, DATA_W=32, BYTES_PER_WORD=4.
REQ-032 One sub-module, byte_packer (byte counter + 32-bit shift assembly, word_ready pulse); FSM in inst_loader.

Verification
REQ-033 WORDS=2, start, bytes 12 34 56 78 AB CD EF 01 back-to-back -> wea at addr 0 data 0x12345678, at addr 1 data 0xABCDEF01, then load_done=1.
REQ-034 Byte gaps: byte_valid low 3 cycles between every byte -> identical writes, no extra wea.
REQ-035 WORDS=64 full load -> 64 wea pulses, addra 0..63, never 64, load_done after 64th.
REQ-036 rst asserted after 2 bytes of word 5 -> all outputs zero immediately; no wea until new start; new session writes from addr 0.
REQ-037 CHECKSUM_EN, WORDS=2, words 0x0000FFFF, 0xFF000000, checksum bytes FF 00 FF FF -> chk_ok=1; checksum 00 00 00 00 -> chk_ok=0.
REQ-038 start pulsed during COLLECT -> ignored, addra continues unchanged.
